pipe_ctrl: RTL and testbench

- Pipeline control unit for the 6-stage MIPS core (pc, if, id, ex, mem, wb).
- Merges per-stage stall requests into the stall vector that every inter-stage register (if/id, id/ex, ...) consumes.
- Sequences exception/ERET redirection: flush pulse, new_pc, then a drain window.
- Includes a stall watchdog that force-redirects a hung pipeline.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_stall_enc.sv | 21 ++
 rtl/pipe_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stall masks, exception codes
// and controller state encoding.
package pipe_ctrl_pkg;

    localparam logic [5:0]  STALL_NONE = 6'b000000;
    localparam logic [5:0]  STALL_IF   = 6'b000011;
    localparam logic [5:0]  STALL_ID   = 6'b000111;
    localparam logic [5:0]  STALL_EX   = 6'b001111;
    localparam logic [5:0]  STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_ERET   = 32'h0000_000E;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    localparam logic        STOP       = 1'b1;
    localparam logic        NO_STOP    = 1'b0;

    typedef enum logic {
        PC_RUN   = 1'b0,
        PC_DRAIN = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-to-controller bundle: per-stage stall requests and exception info in,
// stall vector and redirect out.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] mem_excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        wdt_timeout;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output mem_excepttype, cp0_epc,
        input  stall, flush, new_pc, wdt_timeout
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  mem_excepttype, cp0_epc,
        output stall, flush, new_pc, wdt_timeout
    );
endinterface

// File: rtl/pipe_stall_enc.sv
// Priority encoder from effective stall requests (mem > ex > id > if) to the
// 6-bit per-stage hold vector.
module pipe_stall_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       req_if,
    input  logic       req_id,
    input  logic       req_ex,
    input  logic       req_mem,
    output logic [5:0] stall
);

    always_comb begin
        stall = STALL_NONE;
        if (req_mem == STOP)     stall = STALL_MEM;
        else if (req_ex == STOP) stall = STALL_EX;
        else if (req_id == STOP) stall = STALL_ID;
        else if (req_if == STOP) stall = STALL_IF;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, exception/ERET redirect with drain window,
// stall watchdog. Optional perf counters under PIPE_PERF_CNT_EN.
//
// state    | meaning
// PC_RUN   | normal operation; exceptions accepted, watchdog counting
// PC_DRAIN | post-flush window; id/ex stall requests and exceptions ignored
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          WDT_LIMIT    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam logic [15:0] WDT_LIM    = 16'(WDT_LIMIT);

    pc_state_t   state;
    logic [3:0]  drain_cnt;
    logic [15:0] wdt_cnt;

    logic        in_run;
    logic        exc_accept;
    logic        wdt_fire;
    logic        flush_c;
    logic [5:0]  stall_c;

    // Every output is forced low while rst is asserted, independent of inputs.
    always_comb begin
        in_run     = rst && (state == PC_RUN);
        exc_accept = in_run && (bus.mem_excepttype != ZERO_WORD) && (bus.stallreq_mem == NO_STOP);
        wdt_fire   = in_run && (WDT_LIM != 16'd0) && (wdt_cnt == WDT_LIM) && !exc_accept;
        flush_c    = exc_accept || wdt_fire;
    end

    pipe_stall_enc u_stall_enc (
        .req_if  (rst && !flush_c && bus.stallreq_if),
        .req_id  (in_run && !flush_c && bus.stallreq_id),
        .req_ex  (in_run && !flush_c && bus.stallreq_ex),
        .req_mem (rst && !flush_c && bus.stallreq_mem),
        .stall   (stall_c)
    );

    always_comb begin
        bus.stall       = stall_c;
        bus.flush       = flush_c;
        bus.wdt_timeout = wdt_fire;
        bus.new_pc      = ZERO_WORD;
        if (exc_accept)
            bus.new_pc = (bus.mem_excepttype == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;
        else if (wdt_fire)
            bus.new_pc = EXC_VECTOR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PC_RUN;
            drain_cnt <= 4'd0;
            wdt_cnt   <= 16'd0;
        end else if (flush_c) begin
            state     <= PC_DRAIN;
            drain_cnt <= DRAIN_LOAD;
            wdt_cnt   <= 16'd0;
        end else if (state == PC_DRAIN) begin
            wdt_cnt   <= 16'd0;
            drain_cnt <= drain_cnt - 4'd1;
            if (drain_cnt <= 4'd1)
                state <= PC_RUN;
        end else if (stall_c != STALL_NONE) begin
            // Saturating: holds at the limit rather than wrapping.
            if (wdt_cnt != WDT_LIM)
                wdt_cnt <= wdt_cnt + 16'd1;
        end else begin
            wdt_cnt <= 16'd0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flush_count  <= 32'd0;
        end else begin
            if (stall_c != STALL_NONE)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush_c)
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam logic [31:0] VEC   = 32'h0000_0020;
    localparam int          DRAIN = 2;
    localparam int          LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
    logic [31:0] m_perf_stall;
    logic [31:0] m_perf_flush;
`endif

    pipe_ctrl #(
        .EXC_VECTOR   (VEC),
        .DRAIN_CYCLES (DRAIN),
        .WDT_LIMIT    (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Model: remaining drain cycles (0 = running) and consecutive stalled cycles.
    int m_drain_left;
    int m_run_stalls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_drain_left = 0;
        m_run_stalls = 0;
`ifdef PIPE_PERF_CNT_EN
        m_perf_stall = 0;
        m_perf_flush = 0;
`endif
    endtask

    task automatic step(input bit r_if, input bit r_id, input bit r_ex, input bit r_mem,
                        input logic [31:0] et, input logic [31:0] epc, input string tag);
        bit          drain;
        bit          exc;
        bit          wdt;
        bit          fl;
        int          level;
        logic [5:0]  e_stall;
        logic [31:0] e_pc;
        bus.stallreq_if    = r_if;
        bus.stallreq_id    = r_id;
        bus.stallreq_ex    = r_ex;
        bus.stallreq_mem   = r_mem;
        bus.mem_excepttype = et;
        bus.cp0_epc        = epc;
        @(negedge clk);
        drain = (m_drain_left > 0);
        exc   = !drain && (et != 0) && !r_mem;
        wdt   = !drain && !exc && (LIMIT != 0) && (m_run_stalls == LIMIT);
        fl    = exc || wdt;
        if (r_mem)               level = 4;
        else if (!drain && r_ex) level = 3;
        else if (!drain && r_id) level = 2;
        else if (r_if)           level = 1;
        else                     level = 0;
        e_stall = (fl || level == 0) ? 6'd0 : 6'((1 << (level + 1)) - 1);
        e_pc    = exc ? ((et == 32'hE) ? epc : VEC) : (wdt ? VEC : 32'd0);
        chk({tag, ".stall"}, 32'(bus.stall), 32'(e_stall));
        chk({tag, ".flush"}, 32'(bus.flush), 32'(fl));
        chk({tag, ".new_pc"}, bus.new_pc, e_pc);
        chk({tag, ".wdt"}, 32'(bus.wdt_timeout), 32'(wdt));
`ifdef PIPE_PERF_CNT_EN
        chk({tag, ".perf_stall"}, perf_stall_cycles, m_perf_stall);
        chk({tag, ".perf_flush"}, perf_flush_count, m_perf_flush);
        if (e_stall != 0) m_perf_stall = m_perf_stall + 1;
        if (fl)           m_perf_flush = m_perf_flush + 1;
`endif
        @(posedge clk);
        if (fl) begin
            m_drain_left = DRAIN;
            m_run_stalls = 0;
        end else if (drain) begin
            m_drain_left = m_drain_left - 1;
            m_run_stalls = 0;
        end else if (e_stall != 0) begin
            m_run_stalls = (m_run_stalls + 1 > LIMIT) ? LIMIT : m_run_stalls + 1;
        end else begin
            m_run_stalls = 0;
        end
        #1;
    endtask

    // Asynchronous reset applied mid-cycle with active requests on the inputs.
    task automatic do_reset(input string tag);
        bus.stallreq_if    = 1'b1;
        bus.stallreq_id    = 1'b1;
        bus.stallreq_ex    = 1'b1;
        bus.stallreq_mem   = 1'b0;
        bus.mem_excepttype = 32'h8;
        #2;
        rst = 1'b0;
        #1;
        chk({tag, ".rst_stall"}, 32'(bus.stall), 32'd0);
        chk({tag, ".rst_flush"}, 32'(bus.flush), 32'd0);
        chk({tag, ".rst_new_pc"}, bus.new_pc, 32'd0);
        chk({tag, ".rst_wdt"}, 32'(bus.wdt_timeout), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        bus.stallreq_if    = 1'b1;
        bus.stallreq_id    = 1'b1;
        bus.stallreq_ex    = 1'b1;
        bus.stallreq_mem   = 1'b1;
        bus.mem_excepttype = 32'h8;
        bus.cp0_epc        = 32'h1234_5678;
        @(negedge clk);
        chk("reset.stall", 32'(bus.stall), 32'd0);
        chk("reset.flush", 32'(bus.flush), 32'd0);
        chk("reset.new_pc", bus.new_pc, 32'd0);
        chk("reset.wdt", 32'(bus.wdt_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1, 1, 1, 1, 32'h8, 32'h0, "release");

        // Reset again so the exception pending above does not leak forward.
        do_reset("r1");
        step(0, 1, 1, 0, 32'h0, 32'h0, "prio_ex");
        step(0, 1, 0, 0, 32'h0, 32'h0, "prio_id");
        step(1, 0, 0, 0, 32'h0, 32'h0, "prio_if");
        step(0, 0, 0, 0, 32'h0, 32'h0, "idle");

        step(0, 0, 0, 0, 32'h8, 32'h0, "sys_n");
        step(0, 1, 0, 0, 32'h0, 32'h0, "sys_n1");
        step(0, 1, 0, 0, 32'h0, 32'h0, "sys_n2");
        step(0, 1, 0, 0, 32'h0, 32'h0, "sys_n3");
        chk("sys_n3.const_stall", 32'(bus.stall), 32'h07);

        step(0, 0, 0, 0, 32'hE, 32'h8000_1234, "eret");
        step(1, 1, 1, 0, 32'h0, 32'h0, "eret_d1");
        step(0, 0, 0, 1, 32'h0, 32'h0, "eret_d2");
        step(0, 0, 0, 0, 32'h0, 32'h0, "eret_run");

        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 1, 32'hC, 32'h0, "defer_hold");
        step(0, 0, 0, 0, 32'hC, 32'h0, "defer_take");

        // Mid-drain asynchronous reset.
        do_reset("r_drain");

        for (int i = 0; i < LIMIT + 1; i++)
            step(0, 0, 1, 0, 32'h0, 32'h0, "wdt");
`ifdef PIPE_PERF_CNT_EN
        @(negedge clk);
        chk("wdt.perf_flush_const", perf_flush_count, 32'd1);
        chk("wdt.perf_stall_const", perf_stall_cycles, 32'd8);
        @(posedge clk);
        #1;
`endif
        step(0, 0, 1, 0, 32'h0, 32'h0, "wdt_drain1");
        step(0, 0, 1, 0, 32'h0, 32'h0, "wdt_drain2");
        step(0, 0, 1, 0, 32'h0, 32'h0, "wdt_rerun");

        // Exception on the same cycle the watchdog would fire.
        do_reset("r_wdt2");
        for (int i = 0; i < LIMIT; i++)
            step(1, 0, 0, 0, 32'h0, 32'h0, "wdt2_count");
        step(1, 0, 0, 0, 32'hE, 32'hCAFE_0000, "wdt2_exc_wins");
        step(0, 0, 0, 0, 32'h0, 32'h0, "wdt2_d1");

        // Mid-stall asynchronous reset.
        step(0, 0, 1, 1, 32'h0, 32'h0, "pre_r3");
        do_reset("r_stall");

        for (int i = 0; i < 600; i++) begin
            logic [31:0] et;
            int          pick;
            pick = int'($urandom_range(0, 19));
            et   = (pick == 0) ? 32'h8 : (pick == 1) ? 32'hE : (pick == 2) ? 32'hC : 32'h0;
            if ($urandom_range(0, 199) == 0)
                do_reset("rnd_rst");
            else
                step(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0),
                     bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 4) == 0),
                     et, $urandom, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
